// File: rtl/lsu.sv
// Load/store unit: issues one load or store at a time on the littlecpu data bus,
// checks alignment, extracts and extends sub-word loads, and aborts silent accesses.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [4:0]  rsp_rd,
   output logic        rsp_misaligned,
   output logic        rsp_timeout,
   output logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q;
   logic [1:0]    addr_lo_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic          store_q;
   logic          misaligned;
   logic          timeout_hit;
   logic [3:0]    store_strb;
   logic [31:0]   store_data;
   logic [31:0]   shifted;
   logic [31:0]   load_data;

   always_comb begin
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // A limit of zero disables the abort entirely.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

   always_comb begin
      store_strb = 4'b1111;
      store_data = req_wdata;
      case (req_size)
         2'b00: begin
            store_strb = 4'b0001 << req_addr[1:0];
            store_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            store_strb = 4'b0011 << req_addr[1:0];
            store_data = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = mem_rdata >> {addr_lo_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Completion is checked before the limit so a last-cycle answer still succeeds.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) state_d = misaligned ? RESP : BUS;
         BUS:  if (mem_valid || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q        <= '0;
         addr_lo_q      <= 2'b00;
         size_q         <= 2'b00;
         uns_q          <= 1'b0;
         store_q        <= 1'b0;
         mem_ready      <= 1'b0;
         mem_addr       <= 32'h0;
         mem_wdata      <= 32'h0;
         mem_wstrb      <= 4'b0000;
         rsp_rdata      <= 32'h0;
         rsp_rd         <= 5'd0;
         rsp_misaligned <= 1'b0;
         rsp_timeout    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_lo_q      <= req_addr[1:0];
                  size_q         <= req_size;
                  uns_q          <= req_unsigned;
                  store_q        <= req_store;
                  rsp_rd         <= req_rd;
                  rsp_rdata      <= 32'h0;
                  rsp_misaligned <= misaligned;
                  rsp_timeout    <= 1'b0;
                  count_q        <= '0;
                  if (!misaligned) begin
                     mem_ready <= 1'b1;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= store_data;
                     mem_wstrb <= req_store ? store_strb : 4'b0000;
                  end
               end
            end
            BUS: begin
               if (mem_valid) begin
                  mem_ready <= 1'b0;
                  rsp_rdata <= store_q ? 32'h0 : load_data;
               end else if (timeout_hit) begin
                  mem_ready   <= 1'b0;
                  rsp_timeout <= 1'b1;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios followed by random loads and stores
// checked against a byte-addressed reference memory.
module tb_lsu;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        rsp_misaligned;
   logic        rsp_timeout;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_valid;
   logic [31:0] mem_rdata;

   lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
      .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Responder controls (written by the main sequence only).
   int resp_delay = 1;
   bit resp_en    = 1'b1;
   int stray_req  = 0;

   logic [31:0] mem_words [0:1023];
   logic [7:0]  ref_mem   [0:4095];

   function automatic logic [31:0] initWord(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   // Memory responder: answers resp_delay cycles after first seeing mem_ready.
   int wait_cnt;
   int stray_done;
   initial begin
      mem_valid  = 1'b0;
      mem_rdata  = 32'h0;
      wait_cnt   = 0;
      stray_done = 0;
      for (int i = 0; i < 1024; i++) mem_words[i] = initWord(i);
      forever begin
         @(posedge clk);
         #1;
         if (mem_valid) begin
            mem_valid = 1'b0;
         end else if (stray_req != stray_done) begin
            stray_done = stray_req;
            mem_rdata  = $urandom;
            mem_valid  = 1'b1;
         end else if (reset && mem_ready && resp_en) begin
            wait_cnt++;
            if (wait_cnt > resp_delay) begin
               wait_cnt = 0;
               for (int j = 0; j < 4; j++)
                  if (mem_wstrb[j]) mem_words[mem_addr[11:2]][8*j +: 8] = mem_wdata[8*j +: 8];
               mem_rdata = mem_words[mem_addr[11:2]];
               mem_valid = 1'b1;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Bus monitor: cycles with mem_ready high, request-field changes while high, responses.
   int          mr_total   = 0;
   int          viol_total = 0;
   int          rsp_total  = 0;
   logic        prev_ready = 1'b0;
   logic [31:0] snap_addr, snap_wdata;
   logic [3:0]  snap_wstrb;
   always @(negedge clk) begin
      if (rsp_valid) rsp_total++;
      if (mem_ready) begin
         mr_total++;
         if (!prev_ready) begin
            snap_addr  = mem_addr;
            snap_wdata = mem_wdata;
            snap_wstrb = mem_wstrb;
         end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata ||
                      mem_wstrb !== snap_wstrb) begin
            viol_total++;
         end
      end
      prev_ready = mem_ready;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit isMisaligned(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd3) return 1'b1;
      return (addr % (32'd1 << size)) != 0;
   endfunction

   function automatic logic [31:0] refLoad(input logic [1:0] size, input bit uns, input logic [31:0] addr);
      int n = 1 << size;
      logic [31:0] v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr[11:0] + 12'(i)]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      return v;
   endfunction

   task automatic refStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      int n = 1 << size;
      for (int i = 0; i < n; i++) ref_mem[addr[11:0] + 12'(i)] = wdata[8*i +: 8];
   endtask

   function automatic logic [3:0] expStrb(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] s = 4'b0000;
      for (int i = 0; i < (1 << size); i++) s[addr[1:0] + 2'(i)] = 1'b1;
      return s;
   endfunction

   // Results of the last applyStimulus call.
   int          got_lat;
   int          got_mr;
   int          got_viol;
   logic [31:0] got_rdata;
   logic [4:0]  got_rd;
   logic        got_mis, got_to, next_ready, next_valid;

   task automatic applyStimulus(input bit st, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd);
      int mr0, v0, guard;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) checkOutput("req_ready_wait", {31'h0, req_ready}, 32'h1);
      mr0 = mr_total;
      v0  = viol_total;
      req_valid    = 1'b1;
      req_store    = st;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got_lat = 0;
      while (got_lat < 60) begin
         @(negedge clk);
         got_lat++;
         if (rsp_valid) break;
      end
      if (!rsp_valid) got_lat = -1;
      got_rdata = rsp_rdata;
      got_rd    = rsp_rd;
      got_mis   = rsp_misaligned;
      got_to    = rsp_timeout;
      got_mr    = mr_total - mr0;
      got_viol  = viol_total - v0;
      @(negedge clk);
      next_ready = req_ready;
      next_valid = rsp_valid;
   endtask

   initial begin
      int rsp0;
      int d;
      logic [31:0] a, w, exp_rd;
      logic [1:0]  sz;
      bit          st, un, mis;
      logic [4:0]  rd;

      for (int i = 0; i < 1024; i++) begin
         w = initWord(i);
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
      end

      reset = 1'b0;
      req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("reset_mem_ready", {31'h0, mem_ready}, 32'h0);
      checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("reset_mis",       {31'h0, rsp_misaligned}, 32'h0);
      checkOutput("reset_to",        {31'h0, rsp_timeout}, 32'h0);
      checkOutput("reset_mem_addr",  mem_addr, 32'h0);
      checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
      checkOutput("reset_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("reset_rsp_rd",    {27'h0, rsp_rd}, 32'h0);
      reset = 1'b1;

      $display("[TB] word store");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h12345678, 5'd1);
      refStore(2'b10, 32'h3FC, 32'h12345678);
      checkOutput("sw_addr",  snap_addr, 32'h3FC);
      checkOutput("sw_wstrb", {28'h0, snap_wstrb}, 32'hF);
      checkOutput("sw_wdata", snap_wdata, 32'h12345678);
      checkOutput("sw_lat",   got_lat, 3);
      checkOutput("sw_mr",    got_mr, 2);
      checkOutput("sw_stable", got_viol, 0);
      checkOutput("sw_rdata", got_rdata, 32'h0);
      checkOutput("sw_flags", {30'h0, got_mis, got_to}, 32'h0);
      checkOutput("sw_next_ready", {31'h0, next_ready}, 32'h1);
      checkOutput("sw_next_valid", {31'h0, next_valid}, 32'h0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h8091A2B3, 5'd2);
      refStore(2'b10, 32'h3FC, 32'h8091A2B3);

      $display("[TB] sub-word loads");
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h3FD, 32'h0, 5'd5);
      checkOutput("lb_rdata", got_rdata, 32'hFFFFFFA2);
      checkOutput("lb_rd",    {27'h0, got_rd}, 32'd5);
      checkOutput("lb_wstrb", {28'h0, snap_wstrb}, 32'h0);
      checkOutput("lb_lat",   got_lat, 3);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h3FD, 32'h0, 5'd6);
      checkOutput("lbu_rdata", got_rdata, 32'h000000A2);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, 5'd7);
      checkOutput("lh_rdata", got_rdata, 32'hFFFF8091);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 5'd8);
      checkOutput("lhu_rdata", got_rdata, 32'h00008091);

      $display("[TB] byte store");
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h3FE, 32'h000000AB, 5'd9);
      refStore(2'b00, 32'h3FE, 32'h000000AB);
      checkOutput("sb_wstrb", {28'h0, snap_wstrb}, 32'h4);
      checkOutput("sb_wdata", snap_wdata, 32'hABABABAB);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 5'd10);
      checkOutput("sb_readback", got_rdata, 32'h80ABA2B3);

      $display("[TB] misaligned");
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, 5'd11);
      checkOutput("mis_mr",    got_mr, 0);
      checkOutput("mis_lat",   got_lat, 1);
      checkOutput("mis_flag",  {31'h0, got_mis}, 32'h1);
      checkOutput("mis_rdata", got_rdata, 32'h0);
      checkOutput("mis_rd",    {27'h0, got_rd}, 32'd11);

      $display("[TB] timeout");
      resp_en = 1'b0;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd12);
      resp_en = 1'b1;
      checkOutput("to_mr",   got_mr, TO);
      checkOutput("to_lat",  got_lat, TO + 1);
      checkOutput("to_flag", {31'h0, got_to}, 32'h1);
      checkOutput("to_mis",  {31'h0, got_mis}, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 5'd13);
      checkOutput("after_to_rdata", got_rdata, 32'h80ABA2B3);
      checkOutput("after_to_lat",   got_lat, 3);
      checkOutput("after_to_flag",  {31'h0, got_to}, 32'h0);

      $display("[TB] reset mid-access");
      resp_en = 1'b0;
      @(negedge clk);
      rsp0 = rsp_total;
      req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h3F8; req_rd = 5'd14;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_bus_mem_ready", {31'h0, mem_ready}, 32'h1);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_async_mem_ready", {31'h0, mem_ready}, 32'h0);
      checkOutput("rst_async_req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      resp_en = 1'b1;
      stray_req++;
      repeat (4) @(negedge clk);
      checkOutput("rst_no_rsp",      rsp_total - rsp0, 0);
      checkOutput("rst_req_ready",   {31'h0, req_ready}, 32'h1);
      checkOutput("rst_mem_ready",   {31'h0, mem_ready}, 32'h0);

      $display("[TB] random traffic");
      for (int k = 0; k < 40; k++) begin
         d  = int'($urandom_range(1, 3));
         resp_delay = d;
         st = 1'($urandom_range(0, 1));
         un = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = 32'h200 + 32'($urandom_range(0, 511));
         w  = $urandom;
         rd = 5'($urandom_range(0, 31));
         mis = isMisaligned(sz, a);
         exp_rd = (mis || st) ? 32'h0 : refLoad(sz, un, a);
         applyStimulus(st, sz, un, a, w, rd);
         if (!mis && st) refStore(sz, a, w);
         checkOutput("rnd_lat",   got_lat, mis ? 1 : d + 2);
         checkOutput("rnd_mr",    got_mr, mis ? 0 : d + 1);
         checkOutput("rnd_rdata", got_rdata, exp_rd);
         checkOutput("rnd_rd",    {27'h0, got_rd}, {27'h0, rd});
         checkOutput("rnd_flags", {30'h0, got_mis, got_to}, {30'h0, mis, 1'b0});
         checkOutput("rnd_stable", got_viol, 0);
         if (!mis) begin
            checkOutput("rnd_addr",  snap_addr, {a[31:2], 2'b00});
            checkOutput("rnd_wstrb", {28'h0, snap_wstrb}, st ? {28'h0, expStrb(sz, a)} : 32'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
